hs_npu_axi_sram_responder: RTL

AXI4 burst responder (slave) backed by an on-chip word-addressed SRAM; the memory-side counterpart to the NPU memory interface's burst master. It serves the NPU's weight, input and result traffic in standalone and FPGA builds, and is the reference memory model in block benches. A single FSM handles one burst at a time, either read or write. Write data is honoured per byte.

---
 rtl/hs_npu_pkg.sv | 22 ++
 rtl/axib_if.sv | 65 ++++++
 rtl/hs_npu_sram_bank.sv | 32 +++
 rtl/hs_npu_axi_sram_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hs_npu_pkg.sv
// Shared NPU bus types: AXI response codes, burst encodings and widths.
package hs_npu_pkg;

  localparam int AXI_ID_W = 4;

  // Transfer size code for a full 32-bit word per beat.
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

endpackage

// File: rtl/axib_if.sv
// AXI4 burst bus bundle (32-bit data) with master and slave views.
interface axib_if;
  import hs_npu_pkg::*;

  logic [AXI_ID_W-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [AXI_ID_W-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [AXI_ID_W-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport m (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport s (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/hs_npu_sram_bank.sv
// DEPTH x 32 single-port synchronous RAM, one byte-wide array per lane,
// registered read data that holds while the read enable is low.
module hs_npu_sram_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    // Byte-lane write and read-enabled registered read.
    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
      if (en) begin
        q_reg <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = q_reg;
  end

endmodule

// File: rtl/hs_npu_axi_sram_responder.sv
// AXI4 burst slave over an on-chip SRAM: one read or write burst at a time,
// INCR word bursts, per-byte write strobes, SLVERR for out-of-range beats.
module hs_npu_axi_sram_responder
  import hs_npu_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic clk,
  input  logic rst,
  axib_if.s    axi
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, R_BURST, W_DATA, W_RESP} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          beat_reg, beat_next;
  logic [7:0]          len_reg, len_next;
  logic [31:0]         addr_reg, addr_next;
  logic [AXI_ID_W-1:0] id_reg, id_next;
  logic                bad_reg, bad_next;
  logic                rerr_reg, rerr_next;
  logic                err_reg, err_next;

  logic                ram_en;
  logic [3:0]          ram_we;
  logic [AW-1:0]       ram_addr;
  logic [31:0]         ram_q;

  logic                ar_ready_int, aw_ready_int;
  logic                ar_hs, aw_hs;
  logic                last_beat;
  logic [31:0]         addr_inc;

  // Byte address inside the window [BASE_ADDR, BASE_ADDR + 4*DEPTH).
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign ar_ready_int = (state_reg == IDLE) && !rst;
  assign aw_ready_int = (state_reg == IDLE) && !rst;
  // A simultaneous AW takes priority, leaving AR pending.
  assign aw_hs     = aw_ready_int && axi.awvalid;
  assign ar_hs     = ar_ready_int && axi.arvalid && !axi.awvalid;
  assign last_beat = (beat_reg == len_reg);
  assign addr_inc  = addr_reg + 32'd4;

  // Next-state, burst bookkeeping and RAM port control.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    id_next    = id_reg;
    bad_next   = bad_reg;
    rerr_next  = rerr_reg;
    err_next   = err_reg;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = word_idx(addr_reg);

    case (state_reg)
      IDLE: begin
        if (aw_hs) begin
          state_next = W_DATA;
          beat_next  = 8'd0;
          len_next   = axi.awlen;
          addr_next  = axi.awaddr;
          id_next    = axi.awid;
          bad_next   = (axi.awsize != AXI_SIZE_WORD) || (axi.awburst != INCR);
          err_next   = 1'b0;
        end else if (ar_hs) begin
          state_next = R_BURST;
          beat_next  = 8'd0;
          len_next   = axi.arlen;
          addr_next  = axi.araddr;
          id_next    = axi.arid;
          bad_next   = (axi.arsize != AXI_SIZE_WORD) || (axi.arburst != INCR);
          ram_en     = 1'b1;
          ram_addr   = word_idx(axi.araddr);
          rerr_next  = (axi.arsize != AXI_SIZE_WORD) || (axi.arburst != INCR) ||
                       !in_range(axi.araddr);
        end
      end

      R_BURST: begin
        if (axi.rready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            // Fetch the following beat only once the current one is taken.
            beat_next = beat_reg + 8'd1;
            addr_next = addr_inc;
            ram_en    = 1'b1;
            ram_addr  = word_idx(addr_inc);
            rerr_next = bad_reg || !in_range(addr_inc);
          end
        end
      end

      W_DATA: begin
        if (axi.wvalid) begin
          if (bad_reg || !in_range(addr_reg)) begin
            err_next = 1'b1;
          end else begin
            ram_we = axi.wstrb;
          end
          if (axi.wlast || last_beat) begin
            // wlast must coincide with beat awlen; either alone is an error.
            if (axi.wlast != last_beat) begin
              err_next = 1'b1;
            end
            state_next = W_RESP;
          end else begin
            beat_next = beat_reg + 8'd1;
            addr_next = addr_inc;
          end
        end
      end

      W_RESP: begin
        if (axi.bready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= 8'd0;
      len_reg   <= 8'd0;
      addr_reg  <= 32'd0;
      id_reg    <= '0;
      bad_reg   <= 1'b0;
      rerr_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      id_reg    <= id_next;
      bad_reg   <= bad_next;
      rerr_reg  <= rerr_next;
      err_reg   <= err_next;
    end
  end

  hs_npu_sram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (axi.wdata),
    .rdata (ram_q)
  );

  assign axi.arready = ar_ready_int;
  assign axi.awready = aw_ready_int;
  assign axi.wready  = (state_reg == W_DATA);
  assign axi.rvalid  = (state_reg == R_BURST);
  assign axi.rlast   = (state_reg == R_BURST) && last_beat;
  assign axi.rdata   = ((state_reg == R_BURST) && !rerr_reg) ? ram_q : 32'd0;
  assign axi.rresp   = rerr_reg ? SLVERR : OKAY;
  assign axi.rid     = id_reg;
  assign axi.bvalid  = (state_reg == W_RESP);
  assign axi.bresp   = err_reg ? SLVERR : OKAY;
  assign axi.bid     = id_reg;

endmodule
